// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control path: opcodes, ALU ops,
// FSM states and error codes.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_ADDR,
        ST_MEM,
        ST_WB_LD,
        ST_EXEC_R,
        ST_WB_R,
        ST_BRANCH,
        ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_TIMEOUT = 2'b10
    } err_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multicycle FSM (master) and the datapath
// plus memory port (slave).
//
// Memory handshake: a request is mem_req=1 with mem_we/addr_sel stable; it is
// accepted in the cycle mem_ready is sampled high, and mem_ready is ignored
// whenever mem_req=0.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    import riscv_ctrl_pkg::*;

    logic [6:0]       opcode;
    logic             alu_zero;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_we;
    logic             mdr_we;
    logic             ab_we;
    logic             alu_src_b;
    logic [1:0]       alu_op;
    logic             alu_out_we;
    logic             reg_we;
    logic             mem_to_reg;
    logic             pc_we;
    logic             pc_sel;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;
    logic             halted;
    logic [1:0]       err_code;
    state_t           dbg_state;

    modport master (
        input  opcode, alu_zero, mem_ready,
        output mem_req, mem_we, addr_sel, ir_we, mdr_we, ab_we, alu_src_b,
               alu_op, alu_out_we, reg_we, mem_to_reg, pc_we, pc_sel, retire,
               retired_cnt, halted, err_code, dbg_state
    );

    modport slave (
        output opcode, alu_zero, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_we, mdr_we, ab_we, alu_src_b,
               alu_op, alu_out_we, reg_we, mem_to_reg, pc_we, pc_sel, retire,
               retired_cnt, halted, err_code, dbg_state
    );

endinterface

// File: rtl/mem_wdog.sv
// Memory watchdog: counts consecutive stalled request cycles and flags the
// cycle in which the stall count would reach MEM_TIMEOUT.
module mem_wdog #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic timeout
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;

    assign stall   = req && !ready;
    assign cnt_d   = stall ? cnt_q + 1'b1 : '0;
    // A ready in the would-be timeout cycle is an acceptance, hence the !ready term.
    assign timeout = stall && (cnt_q == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM (lw, sw, beq, R-type) with memory handshake,
// watchdog-driven bus error and retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);
    state_t           state_q, state_d;
    err_t             err_q, err_d;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout, is_store;

    logic       mem_req, mem_we, addr_sel, ir_we, mdr_we, ab_we, alu_src_b;
    logic [1:0] alu_op;
    logic       alu_out_we, reg_we, mem_to_reg, pc_we, pc_sel, retire, halted;

    assign is_store = (bus.opcode == OP_STORE);

    mem_wdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_req),
        .ready   (bus.mem_ready),
        .timeout (timeout)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        ab_we      = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        alu_out_we = 1'b0;
        reg_we     = 1'b0;
        mem_to_reg = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 1'b0;
        retire     = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ab_we = 1'b1;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = ST_ADDR;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_RTYPE:          state_d = ST_EXEC_R;
                    default: begin
                        state_d = ST_HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            ST_ADDR: begin
                alu_src_b  = 1'b1;
                alu_out_we = 1'b1;
                state_d    = ST_MEM;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = is_store;
                if (bus.mem_ready) begin
                    if (is_store) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = ST_WB_LD;
                    end
                end else if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_WB_LD: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXEC_R: begin
                alu_op     = ALU_FUNCT;
                alu_out_we = 1'b1;
                state_d    = ST_WB_R;
            end
            ST_WB_R: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_op  = ALU_SUB;
                pc_we   = 1'b1;
                pc_sel  = bus.alu_zero;
                retire  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (retire) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_we      = mem_we;
    assign bus.addr_sel    = addr_sel;
    assign bus.ir_we       = ir_we;
    assign bus.mdr_we      = mdr_we;
    assign bus.ab_we       = ab_we;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_op      = alu_op;
    assign bus.alu_out_we  = alu_out_we;
    assign bus.reg_we      = reg_we;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.pc_we       = pc_we;
    assign bus.pc_sel      = pc_sel;
    assign bus.retire      = retire;
    assign bus.retired_cnt = cnt_q;
    assign bus.halted      = halted;
    assign bus.err_code    = err_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle control-word tables per scenario plus a
// retire scoreboard holding expected {pc_sel, retired_cnt}.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    localparam int TB_CNT_W = 4;
    localparam int W        = 1 + TB_CNT_W;

    localparam logic [15:0] C_REQ   = 16'h8000;
    localparam logic [15:0] C_WE    = 16'h4000;
    localparam logic [15:0] C_ADDR  = 16'h2000;
    localparam logic [15:0] C_IR    = 16'h1000;
    localparam logic [15:0] C_MDR   = 16'h0800;
    localparam logic [15:0] C_AB    = 16'h0400;
    localparam logic [15:0] C_SRCB  = 16'h0200;
    localparam logic [15:0] C_FUNCT = 16'h0100;
    localparam logic [15:0] C_SUB   = 16'h0080;
    localparam logic [15:0] C_AOUT  = 16'h0040;
    localparam logic [15:0] C_REGWE = 16'h0020;
    localparam logic [15:0] C_M2R   = 16'h0010;
    localparam logic [15:0] C_PCWE  = 16'h0008;
    localparam logic [15:0] C_PCSEL = 16'h0004;
    localparam logic [15:0] C_RET   = 16'h0002;
    localparam logic [15:0] C_HALT  = 16'h0001;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] ctl;
    assign ctl = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.mdr_we,
                  bus.ab_we, bus.alu_src_b, bus.alu_op, bus.alu_out_we, bus.reg_we,
                  bus.mem_to_reg, bus.pc_we, bus.pc_sel, bus.retire, bus.halted};

    int total = 0;
    int bad   = 0;

    logic [W-1:0]        exp_q[$];
    logic [W-1:0]        sb_e;
    logic [TB_CNT_W-1:0] model_cnt;
    logic [15:0]         ex[$];
    logic                rd[$];
    logic                zr[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.retire === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_retire: got unexpected retire, want none");
            end else begin
                sb_e = exp_q.pop_front();
                if ({bus.pc_sel, bus.retired_cnt} !== sb_e) begin
                    bad++;
                    $display("FAIL sb_retire: got {pc_sel,cnt}=%h want %h",
                             {bus.pc_sel, bus.retired_cnt}, sb_e);
                end
            end
        end
    end

    task automatic push_retire(input logic psel);
        exp_q.push_back({psel, model_cnt});
        model_cnt = model_cnt + 1'b1;
    endtask

    task automatic add(input logic [15:0] e, input logic r);
        ex.push_back(e);
        rd.push_back(r);
        zr.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic clear_tab();
        ex.delete();
        rd.delete();
        zr.delete();
    endtask

    // Returns at posedge+1 of the single RST cycle following release.
    task automatic do_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        bus.alu_zero  = 1'b0;
        bus.opcode    = '0;
        exp_q.delete();
        model_cnt = '0;
        clear_tab();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b1;
        bus.opcode    = OP_LOAD;
        model_cnt     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (ctl !== 16'h0) begin bad++; $display("FAIL rst_ctl: got %h want 0000", ctl); end
        if (bus.retired_cnt !== '0) begin bad++; $display("FAIL rst_cnt: got %h want 0", bus.retired_cnt); end
        if (bus.err_code !== 2'b00) begin bad++; $display("FAIL rst_err: got %b want 00", bus.err_code); end
        if (bus.dbg_state !== ST_RST) begin bad++; $display("FAIL rst_state: got %0d want %0d", bus.dbg_state, ST_RST); end
    endtask

    task automatic test_lw();
        do_reset();
        bus.opcode = OP_LOAD;
        push_retire(1'b0);
        add(16'h0, 1'b1);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_SRCB | C_AOUT, 1'b1);
        add(C_REQ | C_ADDR | C_MDR, 1'b1);
        add(C_REGWE | C_M2R | C_PCWE | C_RET, 1'b1);
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL lw_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total += 2;
        if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL lw_cnt: got %0d want 1", bus.retired_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL lw_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_sw_wait();
        do_reset();
        bus.opcode = OP_STORE;
        push_retire(1'b0);
        add(16'h0, 1'b1);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_SRCB | C_AOUT, 1'b0);
        repeat (3) add(C_REQ | C_WE | C_ADDR, 1'b0);
        add(C_REQ | C_WE | C_ADDR | C_PCWE | C_RET, 1'b1);
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL sw_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total += 2;
        if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL sw_cnt: got %0d want 1", bus.retired_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL sw_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_beq();
        do_reset();
        bus.opcode = OP_BRANCH;
        push_retire(1'b1);
        push_retire(1'b0);
        add(16'h0, 1'b1);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_SUB | C_PCWE | C_PCSEL | C_RET, 1'b1);
        zr[3] = 1'b1;
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_SUB | C_PCWE | C_RET, 1'b1);
        zr[6] = 1'b0;
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL beq_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total += 2;
        if (bus.retired_cnt !== 4'd2) begin bad++; $display("FAIL beq_cnt: got %0d want 2", bus.retired_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL beq_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.opcode = 7'b1111111;
        add(16'h0, 1'b1);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        repeat (20) add(C_HALT, 1'($urandom_range(0, 1)));
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL ill_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++;
        if (bus.err_code !== 2'b01) begin bad++; $display("FAIL ill_err: got %b want 01", bus.err_code); end
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (ctl !== 16'h0) begin bad++; $display("FAIL ill_rst_ctl: got %h want 0000", ctl); end
        if (bus.err_code !== 2'b00) begin bad++; $display("FAIL ill_rst_err: got %b want 00", bus.err_code); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.opcode = OP_LOAD;
        add(16'h0, 1'b0);
        repeat (16) add(C_REQ, 1'b0);
        add(C_HALT, 1'b0);
        add(C_HALT, 1'b1);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL to_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++;
        if (bus.err_code !== 2'b10) begin bad++; $display("FAIL to_err: got %b want 10", bus.err_code); end

        // Ready on the last allowed cycle, in both FETCH and MEM.
        do_reset();
        bus.opcode = OP_LOAD;
        push_retire(1'b0);
        add(16'h0, 1'b0);
        repeat (15) add(C_REQ, 1'b0);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b0);
        add(C_SRCB | C_AOUT, 1'b0);
        repeat (15) add(C_REQ | C_ADDR, 1'b0);
        add(C_REQ | C_ADDR | C_MDR, 1'b1);
        add(C_REGWE | C_M2R | C_PCWE | C_RET, 1'b0);
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL edge_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total += 3;
        if (bus.err_code !== 2'b00) begin bad++; $display("FAIL edge_err: got %b want 00", bus.err_code); end
        if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL edge_cnt: got %0d want 1", bus.retired_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL edge_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.opcode = OP_RTYPE;
        push_retire(1'b0);
        add(16'h0, 1'b1);
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_FUNCT | C_AOUT, 1'b1);
        add(C_REGWE | C_PCWE | C_RET, 1'b1);
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL rm_r_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        clear_tab();
        bus.opcode = OP_LOAD;
        add(C_REQ | C_IR, 1'b1);
        add(C_AB, 1'b1);
        add(C_SRCB | C_AOUT, 1'b0);
        add(C_REQ | C_ADDR, 1'b0);
        add(C_REQ | C_ADDR, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL rm_lw_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total++;
        if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL rm_cnt_pre: got %0d want 1", bus.retired_cnt); end
        bus.mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total += 2;
        if (ctl !== 16'h0) begin bad++; $display("FAIL rm_async_ctl: got %h want 0000", ctl); end
        if (bus.retired_cnt !== 4'd0) begin bad++; $display("FAIL rm_cnt: got %0d want 0", bus.retired_cnt); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        total += 2;
        if (ctl !== 16'h0) begin bad++; $display("FAIL rm_rst_ctl: got %h want 0000", ctl); end
        if (bus.dbg_state !== ST_RST) begin bad++; $display("FAIL rm_state: got %0d want %0d", bus.dbg_state, ST_RST); end
        @(posedge clk); #1 bus.mem_ready = 1'b0;
        @(negedge clk);
        total += 2;
        if (ctl !== C_REQ) begin bad++; $display("FAIL rm_fetch: got %h want %h", ctl, C_REQ); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL rm_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back_wrap();
        do_reset();
        bus.opcode = OP_RTYPE;
        add(16'h0, 1'b1);
        for (int k = 0; k < 17; k++) begin
            push_retire(1'b0);
            add(C_REQ | C_IR, 1'b1);
            add(C_AB, 1'b1);
            add(C_FUNCT | C_AOUT, 1'b1);
            add(C_REGWE | C_PCWE | C_RET, 1'b1);
        end
        add(C_REQ, 1'b0);
        for (int i = 0; i < ex.size(); i++) begin
            bus.mem_ready = rd[i];
            bus.alu_zero  = zr[i];
            @(negedge clk);
            total++;
            if (ctl !== ex[i]) begin bad++; $display("FAIL wrap_ctl[%0d]: got %h want %h", i, ctl, ex[i]); end
            @(posedge clk); #1;
        end
        total += 2;
        if (bus.retired_cnt !== 4'd1) begin bad++; $display("FAIL wrap_cnt: got %0d want 1", bus.retired_cnt); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_sb: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
